// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bit counter: FSM state encoding and default widths.
package spi_pkg;

    localparam int SPI_CNT_W   = 5;
    localparam int SPI_BURST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// SPI bit/frame counter: counts enabled bit ticks across one frame or a burst of frames.
// Multi-frame bursts are built only when SPI_BITCNT_BURST_EN is defined.
//
// Handshake: start is a single-cycle request, accepted only in IDLE with a
// non-zero frame_len and no abort; enable is a per-cycle bit tick honoured only
// in RUN; abort wins over everything in the same cycle.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int CNT_W   = SPI_CNT_W,
    parameter int BURST_W = SPI_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   frame_len,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               enable,
    input  logic               abort,
    output logic               busy,
    output logic [CNT_W-1:0]   bit_idx,
    output logic               last_bit,
    output logic [BURST_W-1:0] frame_idx,
    output logic               frame_done,
    output logic               burst_done,
    output logic               len_err,
    output spi_state_t         dbg_state
);

    localparam logic [CNT_W-1:0]   ONE_B = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] ONE_F = {{(BURST_W-1){1'b0}}, 1'b1};

    spi_state_t         r_state;
    spi_state_t         w_next_state;
    logic [CNT_W-1:0]   r_bit_idx;
    logic [BURST_W-1:0] r_frame_idx;
    logic [CNT_W-1:0]   r_len_q;
    logic [BURST_W-1:0] r_burst_q;
    logic               r_frame_done;
    logic               r_len_err;

    logic               w_last_bit;
    logic               w_last_frame;
    logic               w_start_ok;
    logic               w_start_bad;
    logic               w_tick;

    assign w_last_bit   = (r_state == ST_RUN) && (r_bit_idx == (r_len_q - ONE_B));
    assign w_last_frame = (r_frame_idx == r_burst_q);
    assign w_start_ok   = (r_state == ST_IDLE) && start && !abort && (frame_len != '0);
    assign w_start_bad  = (r_state == ST_IDLE) && start && !abort && (frame_len == '0);
    assign w_tick       = (r_state == ST_RUN) && enable && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start_ok) w_next_state = ST_RUN;
                ST_RUN:  if (w_tick && w_last_bit && w_last_frame) w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
        last_bit   = w_last_bit;
        burst_done = (r_state == ST_DONE);
        dbg_state  = r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx    <= '0;
            r_frame_idx  <= '0;
            r_len_q      <= '0;
            r_burst_q    <= '0;
            r_frame_done <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_frame_done <= w_tick && w_last_bit;
            r_len_err    <= w_start_bad;
            if (abort) begin
                r_bit_idx   <= '0;
                r_frame_idx <= '0;
            end else if (w_start_ok) begin
                r_len_q     <= frame_len;
`ifdef SPI_BITCNT_BURST_EN
                r_burst_q   <= burst_len;
`else
                // Single-frame build: burst length is forced to zero frames extra.
                r_burst_q   <= burst_len & {BURST_W{1'b0}};
`endif
                r_bit_idx   <= '0;
                r_frame_idx <= '0;
            end else if (w_tick) begin
                if (w_last_bit) begin
                    r_bit_idx <= '0;
                    if (!w_last_frame) begin
                        r_frame_idx <= r_frame_idx + ONE_F;
                    end
                end else begin
                    r_bit_idx <= r_bit_idx + ONE_B;
                end
            end
        end
    end

    assign bit_idx    = r_bit_idx;
    assign frame_idx  = r_frame_idx;
    assign frame_done = r_frame_done;
    assign len_err    = r_len_err;

endmodule

// File: tb/tb_spi_bit_counter.sv
// Self-checking bench for spi_bit_counter: directed scenarios plus random traffic
// against a transfer-level model (bits counted so far across the whole transfer).
module tb_spi_bit_counter;
  import spi_pkg::*;

  localparam int CW = 5;
  localparam int BW = 4;
`ifdef SPI_BITCNT_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [CW-1:0] frame_len;
  logic [BW-1:0] burst_len;
  logic enable;
  logic abort;
  logic busy;
  logic [CW-1:0] bit_idx;
  logic last_bit;
  logic [BW-1:0] frame_idx;
  logic frame_done;
  logic burst_done;
  logic len_err;
  spi_state_t dbg_state;

  spi_bit_counter #(.CNT_W(CW), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .burst_len(burst_len), .enable(enable), .abort(abort), .busy(busy),
    .bit_idx(bit_idx), .last_bit(last_bit), .frame_idx(frame_idx),
    .frame_done(frame_done), .burst_done(burst_done), .len_err(len_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  // model: transfer described by length, frame count and total bits counted
  bit m_act, m_done;
  int m_len, m_frames, m_count, m_fidx;

  int busy_cnt, fd_cnt, coincide_cnt, le_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_done = 0; m_len = 0; m_frames = 1; m_count = 0; m_fidx = 0;
  endtask

  task automatic clear_stats();
    busy_cnt = 0; fd_cnt = 0; coincide_cnt = 0; le_cnt = 0;
  endtask

  task automatic check_outputs(input int nfd, input int nle);
    int e_bit, e_fidx, e_last;
    spi_state_t e_st;
    e_bit  = m_act ? (m_count % m_len) : 0;
    e_fidx = m_act ? (m_count / m_len) : m_fidx;
    e_last = (m_act && (m_count % m_len == m_len - 1)) ? 1 : 0;
    e_st   = m_act ? ST_RUN : (m_done ? ST_DONE : ST_IDLE);
    check_val("busy", busy, (m_act || m_done) ? 1 : 0);
    check_val("bit_idx", bit_idx, e_bit);
    check_val("frame_idx", frame_idx, e_fidx);
    check_val("last_bit", last_bit, e_last);
    check_val("frame_done", frame_done, nfd);
    check_val("burst_done", burst_done, m_done ? 1 : 0);
    check_val("len_err", len_err, nle);
    check_val("state", dbg_state, e_st);
  endtask

  // driver: one clock cycle of inputs, then model update and compare
  task automatic step(input bit st, input int fl, input int bl, input bit en, input bit ab);
    int nfd, nle;
    @(negedge clk);
    start = st; frame_len = fl[CW-1:0]; burst_len = bl[BW-1:0]; enable = en; abort = ab;
    @(posedge clk);
    cyc++;
    nfd = 0; nle = 0;
    if (ab) begin
      m_act = 0; m_done = 0; m_count = 0; m_fidx = 0;
    end else if (m_act) begin
      if (en) begin
        m_count++;
        if (m_count % m_len == 0) nfd = 1;
        if (m_count == m_len * m_frames) begin
          m_act = 0; m_done = 1; m_fidx = m_frames - 1; m_count = 0;
        end
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (st) begin
      if (fl != 0) begin
        m_act = 1; m_len = fl; m_frames = BURST ? bl + 1 : 1; m_count = 0; m_fidx = 0;
      end else begin
        nle = 1;
      end
    end
    if (nfd != 0) exp_q.push_back(cyc);
    #1;
    check_outputs(nfd, nle);
    if (frame_done) begin
      if (exp_q.size() == 0) check_val("fd_unexpected", 1, 0);
      else check_val("fd_cycle", cyc, exp_q.pop_front());
    end
    if (busy) busy_cnt++;
    if (frame_done) fd_cnt++;
    if (frame_done && burst_done) coincide_cnt++;
    if (len_err) le_cnt++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; frame_len = 0; burst_len = 0; enable = 0; abort = 0;
    model_reset();
    clear_stats();
    #1;
    check_val("reset_busy", busy, 0);
    check_val("reset_bit_idx", bit_idx, 0);
    check_val("reset_frame_idx", frame_idx, 0);
    check_val("reset_pulses", {frame_done, burst_done, len_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // single frame of 10 bits, enable always high
    clear_stats();
    step(1, 10, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
    check_val("single_busy_cycles", busy_cnt, 11);
    check_val("single_fd_count", fd_cnt, 1);
    check_val("single_coincide", coincide_cnt, 1);

    // burst: 8-bit frames, burst_len=2
    clear_stats();
    step(1, 8, 2, 1, 0);
    for (int i = 0; i < 27; i++) step(0, 0, 0, 1, 0);
    check_val("burst_fd_count", fd_cnt, BURST ? 3 : 1);
    check_val("burst_coincide", coincide_cnt, 1);

    // sparse enable: every third cycle
    clear_stats();
    step(1, 4, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0, (i % 3) == 2, 0);
    check_val("sparse_fd_count", fd_cnt, 1);

    // rejected start, then start ignored during RUN
    clear_stats();
    step(1, 0, 0, 0, 0);
    idle_steps(2);
    check_val("len_err_count", le_cnt, 1);
    check_val("len_err_busy", busy_cnt, 0);
    step(1, 10, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(1, 3, 5, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);

    // abort at bit 5, and abort together with start in IDLE
    clear_stats();
    step(1, 10, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    check_val("abort_pre_bit", bit_idx, 5);
    step(0, 0, 0, 1, 1);
    step(1, 6, 0, 1, 1);
    idle_steps(3);
    check_val("abort_fd_count", fd_cnt, 0);
    check_val("abort_busy_cycles", busy_cnt, 6);

    // all-ones frame length
    clear_stats();
    step(1, 31, 0, 1, 0);
    for (int i = 0; i < 33; i++) step(0, 0, 0, 1, 0);
    check_val("maxlen_busy_cycles", busy_cnt, 32);

    // asynchronous reset between edges mid-burst
    clear_stats();
    step(1, 4, 3, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_bit_idx", bit_idx, 0);
    check_val("arst_frame_idx", frame_idx, 0);
    check_val("arst_last_bit", last_bit, 0);
    check_val("arst_pulses", {frame_done, burst_done, len_err}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    check_val("arst_no_done", fd_cnt + coincide_cnt, 0);

    // single-frame behaviour in the default build with burst_len=3
    clear_stats();
    step(1, 4, 3, 1, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 0);
    check_val("bl3_fd_count", fd_cnt, BURST ? 4 : 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int fl;
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
      step($urandom_range(0, 5) == 0, fl, $urandom_range(0, 15),
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    idle_steps(4);
    check_val("fd_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_bit_counter.md
SPI_BIT_COUNTER -- requirements
Module: spi_bit_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 5: width of bit counter and frame_len; max frame 2^CNT_W-1 bits.
REQ-002 SHALL have parameter BURST_W, default 4: width of burst_len and frame_idx.
REQ-003 SHALL have clk  in  1: single clock; all state changes on rising edge.
REQ-004 SHALL have rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have start  in  1: one-cycle request to begin a transfer.
REQ-006 SHALL have frame_len  in  CNT_W: bits per frame; sampled on accepted start.
REQ-007 SHALL have burst_len  in  BURST_W: frames per transfer minus one; sampled on accepted start.
REQ-008 SHALL have enable  in  1: bit tick; one bit is counted per cycle in which it is high.
REQ-009 SHALL have abort  in  1: synchronous cancel of any transfer.
REQ-010 SHALL have busy  out  1: high in RUN and DONE.
REQ-011 SHALL have bit_idx  out  CNT_W: index of the current bit in the frame.
REQ-012 SHALL have last_bit  out  1: combinational; high when state is RUN and bit_idx == len_q-1.
REQ-013 SHALL have frame_idx  out  BURST_W: index of the current frame.
REQ-014 SHALL have frame_done  out  1: registered one-cycle pulse after a frame's last bit is counted.
REQ-015 SHALL have burst_done  out  1: one-cycle pulse, high while in DONE.
REQ-016 SHALL have len_err  out  1: registered one-cycle pulse on rejected start.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL, in IDLE, on start with frame_len != 0: latch len_q/burst_q, clear bit_idx and frame_idx, and enter RUN next cycle.
REQ-019 SHALL, in IDLE, on start with frame_len == 0: stay in IDLE and pulse len_err next cycle.
REQ-020 SHALL, in RUN with enable and not last_bit: increment bit_idx by 1.
REQ-021 SHALL, in RUN with enable and last_bit: clear bit_idx, pulse frame_done next cycle, then do one of the following.
  - frame_idx == burst_q: enter DONE.
  - otherwise: increment frame_idx.
REQ-022 SHALL, in RUN without enable: hold all counters.
REQ-023 SHALL leave DONE for IDLE unconditionally after one cycle; frame_done and burst_done are high in the same cycle for the final frame.
REQ-024 SHALL ignore start while busy; latched lengths stay unchanged.
REQ-025 SHALL give abort priority over start and enable in every state.
  - Next state IDLE; bit_idx and frame_idx cleared.
  - No frame_done, burst_done or len_err generated in that cycle.
REQ-026 SHALL, when frame_len is all ones, count to 2^CNT_W-2 and never wrap bit_idx.
REQ-027 SHALL NOT let bit_idx exceed len_q-1 or frame_idx exceed burst_q under any input sequence.

Reset
REQ-028 SHALL, on rst high, immediately force the following, independent of clk.
  - state IDLE.
  - bit_idx, frame_idx, len_q, burst_q = 0.
  - busy, frame_done, burst_done, len_err = 0.
REQ-029 SHALL, on rst asserted mid-transfer, discard the transfer with no done pulse after release.

Configuration
REQ-030 SHALL use macro SPI_BITCNT_BURST_EN.
  - Defined: multi-frame bursts per REQ-021.
  - Undefined: burst_len is ignored, burst_q is treated as 0, frame_idx is constant 0, and every transfer is exactly one frame.

Structure
REQ-031 SHALL take the FSM state enum type and its encodings from shared package spi_pkg.
REQ-032 SHALL take default width constants SPI_CNT_W=5 and SPI_BURST_W=4 from spi_pkg.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 SHALL cover single frame: frame_len=10, burst_len=0, enable always high.
  - busy high 11 cycles, 10 counted bits plus DONE.
  - last_bit high at bit_idx=9.
  - frame_done and burst_done coincide once.
REQ-035 SHALL cover burst (macro defined): frame_len=8, burst_len=2.
  - Three frame_done pulses 8 enabled cycles apart.
  - frame_idx 0→1→2.
  - burst_done with the third pulse.
REQ-036 SHALL cover sparse enable: frame_len=4, enable every 3rd cycle.
  - bit_idx holds between ticks.
  - frame_done exactly 1 cycle after the 4th tick.
REQ-037 SHALL cover error and ignore cases.
  - start with frame_len=0: len_err one pulse, busy stays 0.
  - start during RUN: ignored, len_q unchanged.
REQ-038 SHALL cover abort.
  - Abort at bit_idx=5 of a 10-bit frame: IDLE next cycle, counters 0, no done pulses.
  - Abort and start together in IDLE: stays IDLE.
REQ-039 SHALL cover asynchronous rst mid-burst, asserted between clock edges.
  - All outputs 0 immediately.
  - No done pulse after release.
  - Macro undefined: burst_len=3 still yields one frame.
